// File: rtl/constant_function_fifo_pkg.sv
// constant_function_fifo_pkg
//   Shared sizing helpers for the constant_function FIFO family.
//   - fn_clog2 : constant function, smallest n with 2**n >= v, minimum 1.
//   - DWIDTH_DEF / DEPTH_DEF : default word width and depth for the family.
package constant_function_fifo_pkg;

    localparam int DWIDTH_DEF = 8;
    localparam int DEPTH_DEF  = 5;

    // Called only in localparam/port-width context; the explicit loop keeps
    // it a legal constant function for older front ends.
    function automatic int fn_clog2(input logic [31:0] v);
        int result;
        result = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((33'd1 << i) < {1'b0, v}) begin
                result = int'(i) + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/constant_function_fifo_mem.sv
// constant_function_fifo_mem
//   DEPTH x DWIDTH register array with one write port and one registered
//   read port. Array contents are never reset; only the read register is.
// Ports:
//   clk      clock (posedge)
//   reset    synchronous active-high reset of the read register
//   wr_en    write strobe, wr_addr/wr_data sampled on the edge
//   rd_en    read strobe, rd_data <= mem[rd_addr] on the edge
//   rd_data  registered read data, holds when rd_en is low
module constant_function_fifo_mem
    import constant_function_fifo_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int AW     = fn_clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [DWIDTH-1:0] rd_data
);

    logic [DWIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/constant_function_fifo.sv
// constant_function_fifo
//   Synchronous FIFO whose pointer and occupancy widths derive from the
//   fn_clog2 constant function. DEPTH need not be a power of two.
//   Optional macro FIFO_COUNT_EN adds the count output.
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   wr_en, wr_data      write request/data, accepted when !full
//   full                registered, high at DEPTH entries
//   rd_en               read request, accepted when !empty
//   rd_data, rd_valid   registered read data, valid one cycle after accept
//   empty               registered, high at 0 entries
//   count               occupancy (only with FIFO_COUNT_EN)
module constant_function_fifo
    import constant_function_fifo_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [DWIDTH-1:0]          wr_data,
    output logic                       full,
    input  logic                       rd_en,
    output logic [DWIDTH-1:0]          rd_data,
    output logic                       rd_valid,
    output logic                       empty
`ifdef FIFO_COUNT_EN
    ,
    output logic [fn_clog2(DEPTH):0]   count
`endif
);

    localparam int AW = fn_clog2(DEPTH);
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   OCC_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   OCC_FULL = (AW+1)'(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   occ;
    logic [AW:0]   occ_next;
    logic          wr_ok;
    logic          rd_ok;

    // Explicit wrap at DEPTH-1 so non-power-of-2 depths never alias.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_ONE;
    endfunction

    // Flags are pre-edge state, so full blocks a write even when a read
    // frees a slot in the same cycle (and likewise empty blocks a read).
    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;

    always_comb begin
        occ_next = occ;
        case ({wr_ok, rd_ok})
            2'b10:   occ_next = occ + OCC_ONE;
            2'b01:   occ_next = occ - OCC_ONE;
            default: occ_next = occ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            rd_valid <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (rd_ok) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            occ      <= occ_next;
            full     <= (occ_next == OCC_FULL);
            empty    <= (occ_next == '0);
            rd_valid <= rd_ok;
        end
    end

    constant_function_fifo_mem #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_ok),
        .wr_addr (wr_ptr),
        .wr_data (wr_data),
        .rd_en   (rd_ok),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

`ifdef FIFO_COUNT_EN
    assign count = occ;
`endif

endmodule

// File: tb/tb_constant_function_fifo.sv
// tb_constant_function_fifo
//   Directed scenarios plus random traffic against a queue-based model of
//   the FIFO. Optional macro FIFO_COUNT_EN also checks the count port.
module tb_constant_function_fifo;
    import constant_function_fifo_pkg::*;

    localparam int DW = 8;
    localparam int DP = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_en = 1'b0;
    logic          full;
    logic          empty;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
`ifdef FIFO_COUNT_EN
    logic [3:0]    count;
`endif

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference model state
    logic [DW-1:0] q[$];
    logic [DW-1:0] exp_data = '0;
    logic          exp_valid = 1'b0;

    always #5 clk = ~clk;

    constant_function_fifo #(
        .DWIDTH (DW),
        .DEPTH  (DP)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .empty    (empty)
`ifdef FIFO_COUNT_EN
        ,
        .count    (count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, advance the model on pre-edge state, compare #1 after the edge.
    task automatic step(input logic rst, input logic we, input logic [DW-1:0] wd, input logic re);
        bit w_acc;
        bit r_acc;
        reset   = rst;
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        w_acc = we && (q.size() < DP);
        r_acc = re && (q.size() > 0);
        @(posedge clk);
        if (rst) begin
            q.delete();
            exp_data  = '0;
            exp_valid = 1'b0;
        end else begin
            exp_valid = r_acc;
            if (r_acc) exp_data = q.pop_front();
            if (w_acc) q.push_back(wd);
        end
        #1;
        check("empty",    32'(empty),    32'(q.size() == 0));
        check("full",     32'(full),     32'(q.size() == DP));
        check("rd_valid", 32'(rd_valid), 32'(exp_valid));
        check("rd_data",  32'(rd_data),  32'(exp_data));
`ifdef FIFO_COUNT_EN
        check("count",    32'(count),    32'(q.size()));
`endif
    endtask

    initial begin
        logic [DW-1:0] v;

        // Sizing of the constant function
        check("clog2_2",  32'(fn_clog2(2)),  32'd1);
        check("clog2_4",  32'(fn_clog2(4)),  32'd2);
        check("clog2_5",  32'(fn_clog2(5)),  32'd3);
        check("clog2_16", 32'(fn_clog2(16)), 32'd4);

        // Reset for two cycles
        @(negedge clk);
        step(1, 0, '0, 0);
        step(1, 0, '0, 0);

        // Fill, overflow drop, drain
        for (int i = 1; i <= 5; i++) begin
            v = DW'(i * 8'h11);
            step(0, 1, v, 0);
        end
        step(0, 1, 8'h66, 0);
        for (int i = 0; i < 6; i++) step(0, 0, '0, 1);

        // Wrap-around: 3 in/out, then 4 in/out
        for (int i = 0; i < 3; i++) step(0, 1, DW'(8'hA0 + i), 0);
        for (int i = 0; i < 3; i++) step(0, 0, '0, 1);
        for (int i = 0; i < 4; i++) step(0, 1, DW'(8'hB0 + i), 0);
        for (int i = 0; i < 4; i++) step(0, 0, '0, 1);

        // Simultaneous: empty -> write only
        step(0, 1, 8'hA5, 1);
        step(0, 0, '0, 1);
        // Fill then both while full -> read only
        for (int i = 0; i < 5; i++) step(0, 1, DW'(8'hC0 + i), 0);
        step(0, 1, 8'hEE, 1);
        // Drain to 2, then both -> occupancy held
        step(0, 0, '0, 1);
        step(0, 0, '0, 1);
        step(0, 1, 8'h5A, 1);
        step(0, 1, 8'h5B, 1);

        // Underflow: drain, then read while empty
        for (int i = 0; i < 4; i++) step(0, 0, '0, 1);
        step(0, 0, '0, 1);
        step(0, 0, '0, 1);

        // Reset with occupancy 3
        for (int i = 0; i < 3; i++) step(0, 1, DW'(8'h30 + i), 0);
        step(1, 1, 8'h77, 1);
        step(0, 1, 8'h78, 0);
        step(0, 0, '0, 1);

        // Random traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 59) == 0), 1'($urandom), DW'($urandom), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
